gpr_sb: RTL

- Parametrised multi-port general purpose register file with an integrated write scoreboard.
- Sits in the ID stage: serves N read ports with same-cycle write bypass, accepts two writeback ports (EX and MEM/load) and tracks outstanding writes per register, so the pipeline controller can stall on read-after-write hazards.

---
 rtl/gpr_sb_pkg.sv | 30 +++
 rtl/gpr_sb_cnt.sv | 51 +++++
 rtl/gpr_sb.sv | 139 +++++++++++++
 3 files changed

// File: rtl/gpr_sb_pkg.sv
// gpr_sb_pkg: shared constants for the gpr_sb register file / scoreboard.
//   - default geometry (data width, register count, address width, ports)
//   - active-low enable and reset polarity constants
//   - writeback port indices and a small hit-count helper
package gpr_sb_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned REG_NUM_DEF  = 32;
  localparam int unsigned ADDR_W_DEF   = 5;
  localparam int unsigned RD_PORTS_DEF = 2;
  localparam int unsigned PEND_W_DEF   = 2;

  // Strobes (we*_, iss_, flush_) are active-low
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Reset is asynchronous, active-low
  localparam logic RST_ACT = 1'b0;

  // Writeback port indices: EX carries the younger instruction
  localparam int unsigned WB_EX    = 0;
  localparam int unsigned WB_MEM   = 1;
  localparam int unsigned WB_PORTS = 2;

  // Number of write ports hitting one address (0..2)
  function automatic logic [1:0] hit_cnt(input logic hit_ex, input logic hit_mem);
    return {1'b0, hit_ex} + {1'b0, hit_mem};
  endfunction

endpackage

// File: rtl/gpr_sb_cnt.sv
// gpr_sb_cnt: one pending-write counter of the scoreboard.
//   clk, reset : clock, asynchronous active-low reset
//   inc_i      : one issue to this register this cycle
//   dec_i      : number of writebacks to this register this cycle (0..2)
//   clr_i      : synchronous clear, wins over inc/dec
//   cnt_o      : current outstanding-write count
module gpr_sb_cnt
  import gpr_sb_pkg::*;
#(
  parameter int unsigned W = PEND_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic [1:0]   dec_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  localparam int unsigned SW = W + 2;
  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0]  cnt_q, cnt_d;
  logic [SW-1:0] sum, dec_eff, nxt;

  // Decrement is clamped so the counter never goes below zero; the top is
  // held at CNT_MAX (issue is blocked upstream when saturated).
  always_comb begin
    sum     = SW'(cnt_q) + SW'(inc_i);
    dec_eff = SW'(dec_i);
    if (dec_eff > sum) begin
      dec_eff = sum;
    end
    nxt   = sum - dec_eff;
    cnt_d = (nxt > SW'(CNT_MAX)) ? CNT_MAX : nxt[W-1:0];
    if (clr_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (reset == RST_ACT) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/gpr_sb.sv
// gpr_sb: multi-port general purpose register file with write scoreboard.
//   clk, reset          : clock, asynchronous active-low reset
//   rd_addr/rd_data     : RD_PORTS read ports, combinational, with write bypass
//   rd_pend, rd_use     : per-port outstanding-write flag / operand-consumed
//   hazard              : any consumed operand still pending
//   we0_/wr_addr0/data0 : EX writeback (active-low enable, wins collisions)
//   we1_/wr_addr1/data1 : MEM/load writeback (active-low enable)
//   iss_/iss_addr       : issue strobe (active-low) and destination register
//   iss_full            : destination counter saturated, issue must be held
//   flush_              : synchronous scoreboard clear (active-low)
// Build option: define GPR_ZERO_REG_EN to hardwire register 0 to zero and
// exclude it from the scoreboard.
module gpr_sb
  import gpr_sb_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned REG_NUM  = REG_NUM_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned RD_PORTS = RD_PORTS_DEF,
  parameter int unsigned PEND_W   = PEND_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  output logic [RD_PORTS-1:0]          rd_pend,
  output logic                         hazard,
  input  logic [RD_PORTS-1:0]          rd_use,
  input  logic                         we0_,
  input  logic [ADDR_W-1:0]            wr_addr0,
  input  logic [DATA_W-1:0]            wr_data0,
  input  logic                         we1_,
  input  logic [ADDR_W-1:0]            wr_addr1,
  input  logic [DATA_W-1:0]            wr_data1,
  input  logic                         iss_,
  input  logic [ADDR_W-1:0]            iss_addr,
  output logic                         iss_full,
  input  logic                         flush_
);

`ifdef GPR_ZERO_REG_EN
  localparam bit ZERO_REG_EN = 1'b1;
`else
  localparam bit ZERO_REG_EN = 1'b0;
`endif

  localparam int unsigned CMP_W = PEND_W + 2;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [WB_PORTS-1:0] wb_en;
  logic [ADDR_W-1:0]   wb_addr [WB_PORTS];
  logic [DATA_W-1:0]   wb_data [WB_PORTS];

  logic [DATA_W-1:0]   regs_q [REG_NUM];
  logic [PEND_W-1:0]   pend   [REG_NUM];

  logic [1:0]          iss_hits;
  logic                iss_inc;
  logic                clr;

  // Effective write enables; address 0 is dropped when it is hardwired
  always_comb begin
    wb_addr[WB_EX]  = wr_addr0;
    wb_addr[WB_MEM] = wr_addr1;
    wb_data[WB_EX]  = wr_data0;
    wb_data[WB_MEM] = wr_data1;
    wb_en[WB_EX]    = (we0_ == ENABLE_) && !(ZERO_REG_EN && (wr_addr0 == '0));
    wb_en[WB_MEM]   = (we1_ == ENABLE_) && !(ZERO_REG_EN && (wr_addr1 == '0));
  end

  // Register array; EX is written last so it wins a same-address collision
  always_ff @(posedge clk or negedge reset) begin
    if (reset == RST_ACT) begin
      for (int r = 0; r < int'(REG_NUM); r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      if (wb_en[WB_MEM]) begin
        regs_q[wb_addr[WB_MEM]] <= wb_data[WB_MEM];
      end
      if (wb_en[WB_EX]) begin
        regs_q[wb_addr[WB_EX]] <= wb_data[WB_EX];
      end
    end
  end

  // Read ports with bypass; pending only if writes this cycle don't cover it
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;
    logic              hit_ex, hit_mem;
    rd_data = '0;
    rd_pend = '0;
    for (int k = 0; k < int'(RD_PORTS); k++) begin
      ra      = rd_addr[k*ADDR_W +: ADDR_W];
      hit_ex  = wb_en[WB_EX]  && (wb_addr[WB_EX]  == ra);
      hit_mem = wb_en[WB_MEM] && (wb_addr[WB_MEM] == ra);
      rv      = regs_q[ra];
      if (hit_ex) begin
        rv = wb_data[WB_EX];
      end else if (hit_mem) begin
        rv = wb_data[WB_MEM];
      end
      rd_data[k*DATA_W +: DATA_W] = rv;
      rd_pend[k] = CMP_W'(pend[ra]) > CMP_W'(hit_cnt(hit_ex, hit_mem));
    end
  end

  assign hazard = |(rd_pend & rd_use);

  // A writeback to the destination this cycle frees a slot, so not full
  assign iss_hits = hit_cnt(wb_en[WB_EX]  && (wb_addr[WB_EX]  == iss_addr),
                            wb_en[WB_MEM] && (wb_addr[WB_MEM] == iss_addr));
  assign iss_full = (pend[iss_addr] == PEND_MAX) && (iss_hits == 2'd0) &&
                    !(ZERO_REG_EN && (iss_addr == '0));
  assign iss_inc  = (iss_ == ENABLE_) && !iss_full;
  assign clr      = (flush_ != DISABLE_);

  for (genvar r = 0; r < int'(REG_NUM); r++) begin : g_pend
    if (ZERO_REG_EN && (r == 0)) begin : g_zero
      assign pend[r] = '0;
    end else begin : g_cnt
      logic       inc;
      logic [1:0] dec;
      assign inc = iss_inc && (iss_addr == ADDR_W'(r));
      assign dec = hit_cnt(wb_en[WB_EX]  && (wb_addr[WB_EX]  == ADDR_W'(r)),
                           wb_en[WB_MEM] && (wb_addr[WB_MEM] == ADDR_W'(r)));
      gpr_sb_cnt #(.W(PEND_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (inc),
        .dec_i (dec),
        .clr_i (clr),
        .cnt_o (pend[r])
      );
    end
  end

endmodule
